writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Writeback stage, directly downstream of execute. Captures one execute result bundle
//  per handshake and applies its side effects in a fixed order: register-file write,
//  then data-memory write (req/ack), then PC and SREG commit.
//  Signals completion to fetch via a one-cycle wb_done pulse.
// PARAMETERS
//  WORD_W       16  datapath width; equals `WORD
//  REG_AW       3   register-file address width (8 GPRs)
//  TIMEOUT_CYC  15  mem_ack wait limit in cycles; used only with WB_TIMEOUT_EN
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       asynchronous reset, active low
//  ex_valid        in   1       execute result bundle valid
//  ex_ready        out  1       1 only in IDLE; capture on ex_valid & ex_ready
//  reg_wb          in   1       bundle requests a register write
//  reg_write_code  in   REG_AW  destination register
//  reg_write_val   in   WORD_W  register write data
//  mem_wb          in   1       bundle requests a memory write
//  mem_write_addr  in   WORD_W  memory address
//  mem_write_val   in   WORD_W  memory write data
//  flag_update     in   1       commit sreg_in to sreg_out
//  sreg_in         in   WORD_W  new status register value
//  jump            in   1       absolute jump
//  pc_jump_loc     in   WORD_W  jump target
//  pc_jump_inc     in   WORD_W  PC increment when jump=0
//  rf_we           out  1       register-file write strobe (one cycle)
//  rf_waddr        out  REG_AW  register-file write address
//  rf_wdata        out  WORD_W  register-file write data
//  mem_req         out  1       memory write request
//  mem_addr        out  WORD_W  memory write address
//  mem_wdata       out  WORD_W  memory write data
//  mem_ack         in   1       memory accepted the write
//  pc_out          out  WORD_W  architectural PC
//  sreg_out        out  WORD_W  architectural status register
//  wb_done         out  1       one-cycle pulse: bundle fully retired
//  wb_err          out  1       sticky mem timeout error (0 without WB_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; all outputs 0 except ex_ready=1.
//    Captured bundle and timeout counter cleared. Reset asserted mid-operation aborts
//    immediately: mem_req drops, pc_out/sreg_out return to 0, no partial commit.
//  - States: IDLE, REG, MEM, COMMIT. Capture edge in IDLE latches every input field.
//  - Exit from IDLE: REG if reg_wb, else MEM if mem_wb, else COMMIT.
//    REG -> MEM if mem_wb, else COMMIT. MEM -> COMMIT on mem_ack.
//  - REG: rf_we=1 for exactly one cycle with the latched waddr/wdata.
//  - MEM: mem_req=1 with mem_addr/mem_wdata held stable until mem_ack is sampled high.
//    mem_req=0 in the cycle after that edge. mem_ack outside MEM is ignored.
//  - COMMIT (one cycle): on the exit edge, pc_out <= jump ? loc : pc_out + inc,
//    modulo 2^WORD_W (wrap, no flag). sreg_out <= sreg_in if flag_update, else held.
//    wb_done is high for the following single cycle, with state already in IDLE.
//  - A new capture is allowed in the same cycle wb_done is high (back-to-back).
//  - Latency from capture edge to wb_done: 2 cycles with neither write; +1 for REG;
//    +N for MEM, where N is the number of cycles mem_req is high.
//  - inc=0 with jump=0 is legal: PC holds.
//  - Register and memory write ordering is never swapped.
// CONFIGURATION
//  WB_TIMEOUT_EN defined:
//    - A counter runs in MEM. If TIMEOUT_CYC cycles elapse with no mem_ack, drop mem_req,
//      set wb_err (sticky until reset), and go to COMMIT; PC/SREG still commit.
//  WB_TIMEOUT_EN undefined:
//    - MEM waits indefinitely; wb_err is tied to 0; no counter logic.
// TESTING
//  T1 rst_n=0 mid-run -> all outputs 0, ex_ready=1, pc_out=0x0000 asynchronously.
//  T2 ALU result: reg_wb=1, code=3, val=0x0005, inc=1
//     -> rf_we one cycle with waddr=3, wdata=0x0005; pc 0x0000->0x0001; wb_done at capture+3.
//  T3 store: mem_wb=1, addr=0x0040, val=0x1234, inc=2, mem_ack after 3 cycles
//     -> mem_req high 3 cycles with addr/data stable; pc +2; no rf_we.
//  T4 jump=1, loc=0x0100, inc=5 -> pc_out=0x0100. pc=0xFFFF, inc=2 -> pc_out=0x0001.
//  T5 flag_update=1, sreg_in=0x0002 -> sreg_out=0x0002; next bundle with flag_update=0
//     -> sreg_out unchanged; back-to-back capture during wb_done accepted.
//  T6 WB_TIMEOUT_EN, mem_ack never asserted -> mem_req drops after 15 cycles; wb_err=1
//     stays high; wb_done pulses.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: retires one execute bundle as reg write -> mem write -> PC/SREG commit.
// Latency: capture to wb_done sampled = 2 cycles, +1 with a reg write, +N mem_req cycles.
// Backpressure: ex_ready only in IDLE; mem side waits on mem_ack (bounded if WB_TIMEOUT_EN).
// Optional feature macro: WB_TIMEOUT_EN (mem_ack timeout with sticky wb_err).
module writeback_unit #(
  parameter int WORD_W      = 16,
  parameter int REG_AW      = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              reg_wb,
  input  logic [REG_AW-1:0] reg_write_code,
  input  logic [WORD_W-1:0] reg_write_val,
  input  logic              mem_wb,
  input  logic [WORD_W-1:0] mem_write_addr,
  input  logic [WORD_W-1:0] mem_write_val,
  input  logic              flag_update,
  input  logic [WORD_W-1:0] sreg_in,
  input  logic              jump,
  input  logic [WORD_W-1:0] pc_jump_loc,
  input  logic [WORD_W-1:0] pc_jump_inc,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [WORD_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] sreg_out,
  output logic              wb_done,
  output logic              wb_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REG    = 2'd1,
    ST_MEM    = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // A zero timeout would make MEM exit before the request is ever visible.
  if (TIMEOUT_CYC < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t state_q, state_d;

  // Captured bundle. reg_wb only steers the exit from IDLE, so it is not kept.
  logic [REG_AW-1:0] rcode_q;
  logic [WORD_W-1:0] rval_q;
  logic              mem_wb_q;
  logic [WORD_W-1:0] maddr_q;
  logic [WORD_W-1:0] mval_q;
  logic              flag_q;
  logic [WORD_W-1:0] sreg_in_q;
  logic              jump_q;
  logic [WORD_W-1:0] loc_q;
  logic [WORD_W-1:0] inc_q;

  // Architectural state and status.
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              done_q, done_d;
  logic              capture;
  logic              mem_timeout;

  assign capture = ex_valid && (state_q == ST_IDLE);

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Timeout fires on the edge that would end the TIMEOUT_CYC-th request cycle unanswered.
  assign mem_timeout = (state_q == ST_MEM) && !mem_ack &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Counter runs only while requesting; it is zero on every entry into MEM.
  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (state_q == ST_MEM && !mem_ack && !mem_timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (mem_timeout) begin
      err_d = 1'b1;
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign wb_err = err_q;
`else
  assign mem_timeout = 1'b0;
  assign wb_err      = 1'b0;
`endif

  // Next-state logic; side effects are sequenced strictly REG -> MEM -> COMMIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (reg_wb) begin
            state_d = ST_REG;
          end else if (mem_wb) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_COMMIT;
          end
        end
      end
      ST_REG: begin
        state_d = mem_wb_q ? ST_MEM : ST_COMMIT;
      end
      ST_MEM: begin
        if (mem_ack || mem_timeout) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Commit values; PC arithmetic wraps naturally at WORD_W bits.
  always_comb begin
    pc_d   = pc_q;
    sreg_d = sreg_q;
    done_d = 1'b0;
    if (state_q == ST_COMMIT) begin
      pc_d   = jump_q ? loc_q : (pc_q + inc_q);
      done_d = 1'b1;
      if (flag_q) begin
        sreg_d = sreg_in_q;
      end
    end
  end

  // State register plus architectural PC/SREG and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      sreg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sreg_q  <= sreg_d;
      done_q  <= done_d;
    end
  end

  // Bundle capture: every field is frozen on the IDLE handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcode_q   <= '0;
      rval_q    <= '0;
      mem_wb_q  <= 1'b0;
      maddr_q   <= '0;
      mval_q    <= '0;
      flag_q    <= 1'b0;
      sreg_in_q <= '0;
      jump_q    <= 1'b0;
      loc_q     <= '0;
      inc_q     <= '0;
    end else if (capture) begin
      rcode_q   <= reg_write_code;
      rval_q    <= reg_write_val;
      mem_wb_q  <= mem_wb;
      maddr_q   <= mem_write_addr;
      mval_q    <= mem_write_val;
      flag_q    <= flag_update;
      sreg_in_q <= sreg_in;
      jump_q    <= jump;
      loc_q     <= pc_jump_loc;
      inc_q     <= pc_jump_inc;
    end
  end

  // Output strobes decode directly from state; data buses come from the captured bundle.
  assign ex_ready  = (state_q == ST_IDLE);
  assign rf_we     = (state_q == ST_REG);
  assign rf_waddr  = rcode_q;
  assign rf_wdata  = rval_q;
  assign mem_req   = (state_q == ST_MEM);
  assign mem_addr  = maddr_q;
  assign mem_wdata = mval_q;
  assign pc_out    = pc_q;
  assign sreg_out  = sreg_q;
  assign wb_done   = done_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, reg/mem/commit sequencing, PC wrap, SREG hold,
// back-to-back capture during wb_done, and the optional mem_ack timeout.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic        reg_wb;
  logic [2:0]  reg_write_code;
  logic [15:0] reg_write_val;
  logic        mem_wb;
  logic [15:0] mem_write_addr;
  logic [15:0] mem_write_val;
  logic        flag_update;
  logic [15:0] sreg_in;
  logic        jump;
  logic [15:0] pc_jump_loc;
  logic [15:0] pc_jump_inc;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] pc_out;
  logic [15:0] sreg_out;
  logic        wb_done;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .reg_wb(reg_wb), .reg_write_code(reg_write_code), .reg_write_val(reg_write_val),
    .mem_wb(mem_wb), .mem_write_addr(mem_write_addr), .mem_write_val(mem_write_val),
    .flag_update(flag_update), .sreg_in(sreg_in),
    .jump(jump), .pc_jump_loc(pc_jump_loc), .pc_jump_inc(pc_jump_inc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .pc_out(pc_out), .sreg_out(sreg_out), .wb_done(wb_done), .wb_err(wb_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; reg_wb = 0; reg_write_code = 0; reg_write_val = 0;
    mem_wb = 0; mem_write_addr = 0; mem_write_val = 0;
    flag_update = 0; sreg_in = 0; jump = 0; pc_jump_loc = 0; pc_jump_inc = 0;
  endtask

  initial begin
    int n;
    rst_n = 0; mem_ack = 0;
    clear_inputs();
    #3;
    check("rst_ex_ready", 16'(ex_ready), 16'h1);
    check("rst_rf_we",    16'(rf_we),    16'h0);
    check("rst_mem_req",  16'(mem_req),  16'h0);
    check("rst_pc",       pc_out,        16'h0000);
    check("rst_sreg",     sreg_out,      16'h0000);
    check("rst_done",     16'(wb_done),  16'h0);
    check("rst_err",      16'(wb_err),   16'h0);
    step();
    rst_n = 1;
    step();

    // T2: register write, pc 0 -> 1, wb_done sampled at capture+3.
    reg_wb = 1; reg_write_code = 3'd3; reg_write_val = 16'h0005; pc_jump_inc = 16'd1;
    ex_valid = 1;
    step();                                   // capture edge
    clear_inputs();
    check("t2_rf_we",     16'(rf_we),    16'h1);
    check("t2_waddr",     16'(rf_waddr), 16'h3);
    check("t2_wdata",     rf_wdata,      16'h0005);
    check("t2_not_ready", 16'(ex_ready), 16'h0);
    step();                                   // COMMIT
    check("t2_rf_we_once", 16'(rf_we),   16'h0);
    check("t2_done_early", 16'(wb_done), 16'h0);
    check("t2_pc_hold",    pc_out,       16'h0000);
    step();
    check("t2_done",  16'(wb_done),  16'h1);
    check("t2_pc",    pc_out,        16'h0001);
    check("t2_ready", 16'(ex_ready), 16'h1);
    step();
    check("t2_done_pulse", 16'(wb_done), 16'h0);

    // T3: store, ack after 3 request cycles, pc +2, no rf_we.
    mem_wb = 1; mem_write_addr = 16'h0040; mem_write_val = 16'h1234; pc_jump_inc = 16'd2;
    ex_valid = 1;
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      check("t3_mem_req", 16'(mem_req), 16'h1);
      check("t3_addr",    mem_addr,     16'h0040);
      check("t3_data",    mem_wdata,    16'h1234);
      check("t3_no_rfwe", 16'(rf_we),   16'h0);
      if (i == 2) mem_ack = 1;
      step();
    end
    mem_ack = 0;
    check("t3_req_drop", 16'(mem_req), 16'h0);
    check("t3_pc_hold",  pc_out,       16'h0001);
    step();
    check("t3_done", 16'(wb_done), 16'h1);
    check("t3_pc",   pc_out,       16'h0003);

    // T4: jump, stray mem_ack ignored, then back-to-back wrap test.
    jump = 1; pc_jump_loc = 16'h0100; pc_jump_inc = 16'd5; mem_ack = 1; ex_valid = 1;
    step();
    clear_inputs();
    check("t4_no_req", 16'(mem_req), 16'h0);
    step();
    mem_ack = 0;
    check("t4_done", 16'(wb_done), 16'h1);
    check("t4_pc",   pc_out,       16'h0100);
    jump = 1; pc_jump_loc = 16'hFFFF; ex_valid = 1;     // offered while wb_done is high
    step();
    clear_inputs();
    check("t4_b2b_busy", 16'(ex_ready), 16'h0);
    step();
    check("t4_pc_ffff", pc_out, 16'hFFFF);
    pc_jump_inc = 16'd2; ex_valid = 1;
    step();
    clear_inputs();
    step();
    check("t4_wrap_done", 16'(wb_done), 16'h1);
    check("t4_wrap_pc",   pc_out,       16'h0001);

    // T5: flag update then hold; inc=0 keeps PC.
    flag_update = 1; sreg_in = 16'h0002; ex_valid = 1;
    step();
    clear_inputs();
    step();
    check("t5_sreg", sreg_out, 16'h0002);
    check("t5_pc",   pc_out,   16'h0001);
    flag_update = 0; sreg_in = 16'h7777; ex_valid = 1;   // back-to-back during wb_done
    step();
    clear_inputs();
    check("t5_b2b_taken", 16'(ex_ready), 16'h0);
    step();
    check("t5_done2",     16'(wb_done), 16'h1);
    check("t5_sreg_hold", sreg_out,     16'h0002);

    // T1: reset asserted while a store is outstanding.
    step();
    mem_wb = 1; mem_write_addr = 16'h0080; mem_write_val = 16'hBEEF; ex_valid = 1;
    step();
    clear_inputs();
    check("t1_req_before", 16'(mem_req), 16'h1);
    #2 rst_n = 0;
    #1;
    check("t1_req",   16'(mem_req),  16'h0);
    check("t1_ready", 16'(ex_ready), 16'h1);
    check("t1_pc",    pc_out,        16'h0000);
    check("t1_sreg",  sreg_out,      16'h0000);
    check("t1_addr",  mem_addr,      16'h0000);
    step();
    rst_n = 1;
    step();
    check("t1_idle_req", 16'(mem_req), 16'h0);

    // T6: no ack ever; bounded wait on mem_req.
    mem_wb = 1; mem_write_addr = 16'h0010; pc_jump_inc = 16'd4; ex_valid = 1;
    step();
    clear_inputs();
`ifdef WB_TIMEOUT_EN
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      step();
    end
    check("t6_req_cycles", 16'(n),      16'd15);
    check("t6_err",        16'(wb_err), 16'h1);
    step();
    check("t6_done", 16'(wb_done), 16'h1);
    check("t6_pc",   pc_out,       16'h0004);
    step();
    check("t6_err_sticky", 16'(wb_err), 16'h1);
`else
    n = 0;
    while (mem_req && n < 25) begin
      n++;
      step();
    end
    check("t6_still_waiting", 16'(mem_req), 16'h1);
    check("t6_no_err",        16'(wb_err),  16'h0);
    mem_ack = 1;
    step();
    mem_ack = 0;
    step();
    check("t6_done", 16'(wb_done), 16'h1);
    check("t6_pc",   pc_out,       16'h0004);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
